// File: rtl/lasd_pkg.sv
// Shared definitions for the next-PC unit: address width, fault vector
// and the RUN/HALT state encoding.
package lasd_pkg;

    localparam int ADDR_W = 8;
    localparam logic [ADDR_W-1:0] FAULT_VEC_DEF = 8'hF0;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    function automatic logic [ADDR_W-1:0] incr(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/return_addr_stack.sv
// Return-address stack: push/pop at the clock edge, combinational top.
// Only the occupancy counter is reset; entry contents are don't-care.
module return_addr_stack
    import lasd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clock_reg,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic [3:0]        depth,
    output logic              full,
    output logic              empty
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [3:0]        cnt;
    logic [IW-1:0]     top_idx;
    logic [IW-1:0]     wr_idx;

    assign top_idx = IW'(cnt - 4'd1);
    assign wr_idx  = IW'(cnt);
    assign top     = mem[top_idx];
    assign depth   = cnt;
    assign full    = (cnt == 4'(DEPTH));
    assign empty   = (cnt == 4'd0);

    always_ff @(posedge clock_reg) begin
        if (!reset) begin
            cnt <= 4'd0;
        end else if (pop && !empty) begin
            cnt <= cnt - 4'd1;
        end else if (push && !full) begin
            cnt <= cnt + 4'd1;
        end
    end

    // Entries carry no reset so the array can map onto plain registers.
    always_ff @(posedge clock_reg) begin
        if (reset && push && !pop && !full) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/next_pc_unit.sv
// Next-PC select with return-address stack, RUN/HALT FSM and stack fault flags.
// Define NEXT_PC_ERR_STICKY_EN to hold stk_ovf/stk_unf until reset.
module next_pc_unit
    import lasd_pkg::*;
#(
    parameter int                DEPTH     = 4,
    parameter logic [ADDR_W-1:0] FAULT_VEC = FAULT_VEC_DEF
) (
    input  logic              clock_reg,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic              jump,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] target,
    input  logic              halt,
    input  logic              resume,
    output logic [ADDR_W-1:0] pc_next,
    output logic [3:0]        depth,
    output logic              halted,
    output logic              stk_ovf,
    output logic              stk_unf
);

    state_t            state, state_d;
    logic              push, pop;
    logic              ovf_ev, unf_ev;
    logic              full, empty;
    logic [ADDR_W-1:0] top;

    return_addr_stack #(.DEPTH(DEPTH)) u_ras (
        .clock_reg (clock_reg),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (incr(pc)),
        .top       (top),
        .depth     (depth),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clock_reg) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        pc_next = incr(pc);
        state_d = state;
        push    = 1'b0;
        pop     = 1'b0;
        ovf_ev  = 1'b0;
        unf_ev  = 1'b0;
        if (!reset) begin
            pc_next = '0;
        end else if (state == HALT) begin
            pc_next = pc;
            if (resume && !halt) state_d = RUN;
        end else begin
            priority case (1'b1)
                halt: begin
                    pc_next = pc;
                    state_d = HALT;
                end
                stall: pc_next = pc;
                ret: begin
                    if (empty) begin
                        pc_next = FAULT_VEC;
                        unf_ev  = 1'b1;
                    end else begin
                        pc_next = top;
                        pop     = 1'b1;
                    end
                end
                call: begin
                    if (full) begin
                        pc_next = FAULT_VEC;
                        ovf_ev  = 1'b1;
                    end else begin
                        pc_next = target;
                        push    = 1'b1;
                    end
                end
                jump, branch_taken: pc_next = target;
                default: pc_next = incr(pc);
            endcase
        end
    end

    assign halted = (state == HALT);

    always_ff @(posedge clock_reg) begin
        if (!reset) begin
            stk_ovf <= 1'b0;
            stk_unf <= 1'b0;
        end else begin
`ifdef NEXT_PC_ERR_STICKY_EN
            stk_ovf <= stk_ovf | ovf_ev;
            stk_unf <= stk_unf | unf_ev;
`else
            stk_ovf <= ovf_ev;
            stk_unf <= unf_ev;
`endif
        end
    end

endmodule

// File: tb/tb_next_pc_unit.sv
// Scoreboard bench for next_pc_unit: expected pc_next queued at drive time,
// popped and compared mid-cycle; registered outputs checked after each edge.
module tb_next_pc_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] pc, target, pc_next;
    logic       stall, branch_taken, jump, call, ret, halt, resume;
    logic [3:0] depth;
    logic       halted, stk_ovf, stk_unf;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q [$];

`ifdef NEXT_PC_ERR_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    always #5 clk = ~clk;

    next_pc_unit #(.DEPTH(4), .FAULT_VEC(8'hF0)) dut (
        .clock_reg    (clk),
        .reset        (rst_n),
        .pc           (pc),
        .stall        (stall),
        .branch_taken (branch_taken),
        .jump         (jump),
        .call         (call),
        .ret          (ret),
        .target       (target),
        .halt         (halt),
        .resume       (resume),
        .pc_next      (pc_next),
        .depth        (depth),
        .halted       (halted),
        .stk_ovf      (stk_ovf),
        .stk_unf      (stk_unf)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ctl bits: {halt, resume, stall, ret, call, jump, branch_taken}
    task automatic step(input string tag, input logic [7:0] p,
                        input logic [6:0] ctl, input logic [7:0] tgt,
                        input logic [7:0] exp);
        pc = p;
        target = tgt;
        {halt, resume, stall, ret, call, jump, branch_taken} = ctl;
        exp_q.push_back(exp);
        @(negedge clk);
        if (exp_q.size() == 0) check({tag, " queue"}, 0, 1);
        else check(tag, pc_next, exp_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] BR   = 7'b0000001;
    localparam logic [6:0] JMP  = 7'b0000010;
    localparam logic [6:0] CALL = 7'b0000100;
    localparam logic [6:0] RET  = 7'b0001000;
    localparam logic [6:0] STL  = 7'b0010000;
    localparam logic [6:0] RES  = 7'b0100000;
    localparam logic [6:0] HLT  = 7'b1000000;

    task automatic regs(input string tag, input logic [3:0] d, input logic h,
                        input logic o, input logic u);
        check({tag, " depth"}, depth, d);
        check({tag, " halted"}, halted, h);
        check({tag, " stk_ovf"}, stk_ovf, o);
        check({tag, " stk_unf"}, stk_unf, u);
    endtask

    initial begin
        rst_n = 1'b0;
        {halt, resume, stall, ret, call, jump, branch_taken} = NONE;
        pc = 8'h55;
        target = 8'h00;
        @(posedge clk);
        #1;
        step("reset pc_next", 8'h55, JMP, 8'h66, 8'h00);
        regs("reset", 4'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        step("seq FE", 8'hFE, NONE, 8'h00, 8'hFF);
        step("seq wrap", 8'hFF, NONE, 8'h00, 8'h00);
        step("branch", 8'h20, BR, 8'h77, 8'h77);
        step("jump", 8'h21, JMP, 8'h99, 8'h99);
        step("stall", 8'h30, STL | JMP | CALL, 8'h99, 8'h30);
        check("stall depth", depth, 0);

        step("call", 8'h10, CALL, 8'h40, 8'h40);
        check("call depth", depth, 1);
        step("ret", 8'h40, RET, 8'h00, 8'h11);
        check("ret depth", depth, 0);

        step("call wrap", 8'hFF, CALL, 8'h12, 8'h12);
        step("ret wrap", 8'h12, RET, 8'h00, 8'h00);

        for (int i = 1; i <= 4; i++) begin
            step("ovf fill", 8'(i), CALL, 8'h80, 8'h80);
            check("ovf fill depth", depth, 4'(i));
        end
        step("ovf call", 8'h05, CALL, 8'h80, 8'hF0);
        regs("ovf", 4'd4, 1'b0, 1'b1, 1'b0);
        step("ovf after", 8'h06, NONE, 8'h00, 8'h07);
        regs("ovf hold", 4'd4, 1'b0, STICKY, 1'b0);
        for (int i = 4; i >= 1; i--) begin
            step("ovf drain", 8'h80, RET, 8'h00, 8'(i + 1));
        end
        check("drain depth", depth, 0);

        step("unf ret+call", 8'h08, RET | CALL, 8'h20, 8'hF0);
        regs("unf", 4'd0, 1'b0, STICKY, 1'b1);
        step("unf after", 8'h09, NONE, 8'h00, 8'h0A);
        regs("unf hold", 4'd0, 1'b0, STICKY, STICKY);

        step("halt", 8'h33, HLT, 8'h00, 8'h33);
        check("halt halted", halted, 1);
        step("halt jump", 8'h33, JMP | CALL, 8'h50, 8'h33);
        check("halt ign halted", halted, 1);
        check("halt ign depth", depth, 0);
        step("halt+resume", 8'h33, HLT | RES, 8'h50, 8'h33);
        check("halt+resume halted", halted, 1);
        step("resume", 8'h33, RES, 8'h50, 8'h33);
        check("resume halted", halted, 0);
        step("jump after", 8'h33, JMP, 8'h50, 8'h50);

        for (int i = 1; i <= 3; i++) begin
            step("mid fill", 8'(i), CALL, 8'h90, 8'h90);
        end
        step("mid halt", 8'h44, HLT, 8'h00, 8'h44);
        regs("mid pre", 4'd3, 1'b1, STICKY, STICKY);
        rst_n = 1'b0;
        step("mid reset", 8'h44, RET | RES, 8'h00, 8'h00);
        rst_n = 1'b1;
        regs("mid post", 4'd0, 1'b0, 1'b0, 1'b0);
        step("post ret", 8'h60, RET, 8'h00, 8'hF0);
        regs("post unf", 4'd0, 1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
